// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   req_id_e    : requester identity (instruction fetch / data memory)
//   STREAK_W    : width of the consecutive-DM-grant counter
//   PERF_W      : width of the optional performance counters
package mem_arb_pkg;
  localparam int STREAK_W = 8;
  localparam int PERF_W   = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;
endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Performance counters for the memory-port arbiter (built only when
// MEM_PORT_ARBITER_PERF_EN is defined). All counters wrap.
//   clk_i, rst_i   : clock, async active-low reset
//   if_grant_i     : one-cycle pulse per IF grant
//   dm_grant_i     : one-cycle pulse per DM grant
//   if_wait_i      : IF requesting but not being served this cycle
//   if_grants_o, dm_grants_o, if_wait_o : counter values
module mem_arb_perf_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_grant_i,
  input  logic              dm_grant_i,
  input  logic              if_wait_i,
  output logic [PERF_W-1:0] if_grants_o,
  output logic [PERF_W-1:0] dm_grants_o,
  output logic [PERF_W-1:0] if_wait_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_grants_o <= '0;
      dm_grants_o <= '0;
      if_wait_o   <= '0;
    end else begin
      if (if_grant_i) if_grants_o <= if_grants_o + 1'b1;
      if (dm_grant_i) dm_grants_o <= dm_grants_o + 1'b1;
      if (if_wait_i)  if_wait_o   <= if_wait_o + 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the
// instruction-fetch (IF) and data-memory (DM) requesters. DM has fixed
// priority, except that after MAX_DM_STREAK consecutive DM grants taken
// while IF was waiting, IF is forced through. Each access runs
// IDLE -> GRANT_x (until mem_ack_i) -> RESP (one-cycle ready) -> IDLE.
// All outputs are registered.
//   clk_i, rst_i           : clock, async active-low reset
//   if_req_i/if_addr_i     : IF read request; if_ready_o/if_rdata_o reply
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : DM request; dm_ready_o/dm_rdata_o reply
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request (held to ack)
//   mem_ack_i/mem_rdata_i  : memory completion and read data
//   arb_busy_o             : high whenever the FSM is not in IDLE
// Optional: define MEM_PORT_ARBITER_PERF_EN to add perf_if_grants_o,
// perf_dm_grants_o and perf_if_wait_o counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              arb_busy_o
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_if_grants_o,
  output logic [PERF_W-1:0] perf_dm_grants_o,
  output logic [PERF_W-1:0] perf_if_wait_o
`endif
);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_e          state_q, state_d;
  req_id_e             winner;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                if_ready_d, dm_ready_d;
  logic [DATA_W-1:0]   if_rdata_d, dm_rdata_d;

  // IF only overtakes a pending DM request once the streak is exhausted.
  assign winner = (dm_req_i && !(if_req_i && streak_q == STREAK_MAX)) ? REQ_DM : REQ_IF;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    // Ready and read data are single-cycle: they fall back to 0 unless
    // loaded on the ack cycle.
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (winner == REQ_DM && dm_req_i) begin
          state_d     = GRANT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          // Streak only grows while IF is actually being held off.
          if (!if_req_i)                streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (if_req_i) begin
          state_d     = GRANT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      GRANT_IF: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata_i;
          // A requester that abandoned its request gets no ready pulse.
          if_ready_d = if_req_i;
        end
      end
      GRANT_DM: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if (!mem_we_o) dm_rdata_d = mem_rdata_i;
          dm_ready_d = dm_req_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ready_o  <= 1'b0;
      if_rdata_o  <= '0;
      dm_ready_o  <= 1'b0;
      dm_rdata_o  <= '0;
      arb_busy_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if_ready_o  <= if_ready_d;
      if_rdata_o  <= if_rdata_d;
      dm_ready_o  <= dm_ready_d;
      dm_rdata_o  <= dm_rdata_d;
      arb_busy_o  <= (state_d != IDLE);
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic if_grant, dm_grant, if_wait;

  assign if_grant = (state_q == IDLE) && (state_d == GRANT_IF);
  assign dm_grant = (state_q == IDLE) && (state_d == GRANT_DM);
  // IF counts as served while its access is outstanding or its ready is out.
  assign if_wait  = if_req_i && !(state_q == GRANT_IF || if_ready_o);

  mem_arb_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_grant_i  (if_grant),
    .dm_grant_i  (dm_grant),
    .if_wait_i   (if_wait),
    .if_grants_o (perf_if_grants_o),
    .dm_grants_o (perf_dm_grants_o),
    .if_wait_o   (perf_if_wait_o)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps followed by
// randomized traffic checked against a behavioural model of the grant
// rule, the streak bound and a shadow memory.
module tb_mem_port_arbiter;
  localparam int MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
  logic        if_ready_o, dm_ready_o;
  logic [31:0] if_rdata_o, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, arb_busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_grants_o, perf_dm_grants_o, perf_if_wait_o;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .arb_busy_o(arb_busy_o)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .perf_if_grants_o(perf_if_grants_o), .perf_dm_grants_o(perf_dm_grants_o),
    .perf_if_wait_o(perf_if_wait_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory: responder copy and model copy ----------------
  logic [31:0] rmem   [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction
  function automatic logic [31:0] rm_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_val(a);
  endfunction
  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  int lat_fix = -1;   // fixed ack latency, or -1 for random 0..3
  int lat_cnt = 0;
  bit active  = 1'b0;

  // Memory responder: acks L cycles after it first sees mem_req_o.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0; mem_rdata_i = '0; active = 1'b0;
      end else if (!mem_req_o) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active  = 1'b1;
          lat_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3, 0));
        end
        if (lat_cnt == 0) begin
          if (mem_we_o) begin
            rmem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = $urandom();   // garbage the DUT must not return
          end else begin
            mem_rdata_i = rm_rd(mem_addr_o);
          end
          mem_ack_i = 1'b1;
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  int          streak_m = 0;
  int          order_q[$];      // 1 = DM grant, 0 = IF grant
  logic        prev_req = 1'b0;
  int          exp_owner = 0;
  logic        served = 1'b1;
  logic        g_we;
  logic [31:0] g_addr, g_wdata;

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(15, 0)) << 2;
  endfunction

  // One cycle of model-checked traffic. pct = chance to issue a new request.
  task automatic model_cycle(input int pct);
    int w;
    @(negedge clk_i);
    if (mem_req_o && !prev_req) begin
      chk("grant_req", 72'(if_req_i | dm_req_i), 72'(1));
      w = (dm_req_i && !(if_req_i && streak_m == MAX)) ? 1 : 0;
      if (w == 1) streak_m = if_req_i ? ((streak_m < MAX) ? streak_m + 1 : MAX) : 0;
      else        streak_m = 0;
      exp_owner = w;
      served    = 1'b0;
      order_q.push_back(w);
      g_we    = (w == 1) ? dm_we_i : 1'b0;
      g_addr  = (w == 1) ? dm_addr_i : if_addr_i;
      g_wdata = (w == 1 && dm_we_i) ? dm_wdata_i : 32'h0;
    end
    if (mem_req_o)
      chk("mem_attr", 72'({arb_busy_o, mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : 32'h0)}),
          72'({1'b1, g_we, g_addr, g_wdata}));
    prev_req = mem_req_o;
    if (if_ready_o || dm_ready_o) begin
      chk("ready_owner", 72'({if_ready_o, dm_ready_o, served}),
          (exp_owner == 1) ? 72'(3'b010) : 72'(3'b100));
      served = 1'b1;
      if (if_ready_o) begin
        chk("if_rdata", 72'(if_rdata_o), 72'(sh_rd(if_addr_i)));
        if_req_i = 1'b0;
      end
      if (dm_ready_o) begin
        if (dm_we_i) begin
          chk("dm_wr_rdata", 72'(dm_rdata_o), 72'(0));
          shadow[dm_addr_i] = dm_wdata_i;
        end else begin
          chk("dm_rdata", 72'(dm_rdata_o), 72'(sh_rd(dm_addr_i)));
        end
        dm_req_i = 1'b0;
      end
    end
    if (!if_req_i && int'($urandom_range(99, 0)) < pct) begin
      if_req_i = 1'b1; if_addr_i = rand_addr();
    end
    if (!dm_req_i && int'($urandom_range(99, 0)) < pct) begin
      dm_req_i = 1'b1; dm_we_i = 1'($urandom_range(1, 0));
      dm_addr_i = rand_addr(); dm_wdata_i = $urandom();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((arb_busy_o || if_req_i || dm_req_i) && n < 100) begin
      model_cycle(0); n++;
    end
    chk("drain_idle", 72'(arb_busy_o | if_req_i | dm_req_i), 72'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    lat_fix = -1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    streak_m = 0; prev_req = 1'b0; served = 1'b1; order_q.delete();
  endtask

  initial begin
    int cyc, pulses;
    int seq_q[$];
    int exp_starve[10];
    exp_starve = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    // ---- reset state ----
    rst_i = 1'b0;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ctl", 72'({if_ready_o, dm_ready_o, mem_req_o, mem_we_o, arb_busy_o}), 72'(0));
    chk("rst_rdata", 72'({if_rdata_o, dm_rdata_o}), 72'(0));
    chk("rst_mem", 72'({mem_addr_o, mem_wdata_o}), 72'(0));
    rst_i = 1'b1;

    // ---- single IF read, ack latency 2 ----
    do_reset();
    lat_fix = 2; rmem[32'h40] = 32'hDEAD_BEEF;
    @(negedge clk_i); if_req_i = 1'b1; if_addr_i = 32'h40;
    @(negedge clk_i);
    chk("if_mem_req", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b0, 32'h40}));
    cyc = 1;
    while (!if_ready_o && cyc < 20) begin @(negedge clk_i); cyc++; end
    chk("if_latency", 72'(cyc), 72'(4));
    chk("if_rdata_dir", 72'(if_rdata_o), 72'(32'hDEAD_BEEF));
    if_req_i = 1'b0;
    @(negedge clk_i);
    chk("if_one_pulse", 72'({if_ready_o, arb_busy_o}), 72'(0));

    // ---- DM write, ack in first cycle ----
    do_reset();
    lat_fix = 0;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'h1234_5678;
    @(negedge clk_i);
    chk("dm_wr_mem", 72'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
        72'({1'b1, 1'b1, 32'h100, 32'h1234_5678}));
    cyc = 1;
    while (!dm_ready_o && cyc < 20) begin @(negedge clk_i); cyc++; end
    chk("dm_wr_latency", 72'(cyc), 72'(2));
    chk("dm_wr_rdata0", 72'(dm_rdata_o), 72'(0));
    chk("dm_wr_stored", 72'(rm_rd(32'h100)), 72'(32'h1234_5678));
    dm_req_i = 1'b0;
    @(negedge clk_i);
    chk("dm_one_pulse", 72'({dm_ready_o, arb_busy_o}), 72'(0));

    // ---- simultaneous requests: DM then IF, one pulse each ----
    do_reset();
    lat_fix = 1;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h8;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'hC;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (dm_ready_o) begin
        seq_q.push_back(1);
        chk("sim_dm_rdata", 72'(dm_rdata_o), 72'(sh_rd(32'hC)));
        dm_req_i = 1'b0;
      end
      if (if_ready_o) begin
        seq_q.push_back(0);
        chk("sim_if_rdata", 72'(if_rdata_o), 72'(sh_rd(32'h8)));
        if_req_i = 1'b0;
      end
    end
    chk("sim_pulses", 72'(seq_q.size()), 72'(2));
    chk("sim_order", 72'({(seq_q.size() > 0) ? seq_q[0] : 9, (seq_q.size() > 1) ? seq_q[1] : 9}),
        72'({32'd1, 32'd0}));

    // ---- early drop: DM abandons its request mid-access ----
    do_reset();
    lat_fix = 3;
    @(negedge clk_i); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
    @(negedge clk_i);
    chk("drop_mem_req", 72'(mem_req_o), 72'(1));
    @(negedge clk_i); dm_req_i = 1'b0;
    pulses = 0; cyc = 0;
    while (arb_busy_o && cyc < 20) begin
      @(negedge clk_i); cyc++;
      if (dm_ready_o || if_ready_o) pulses++;
    end
    chk("drop_done", 72'(cyc < 20), 72'(1));
    chk("drop_no_ready", 72'(pulses), 72'(0));
    chk("drop_idle", 72'({mem_req_o, arb_busy_o}), 72'(0));

    // ---- reset in the middle of a DM access ----
    do_reset();
    lat_fix = 10;
    @(negedge clk_i); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'h55;
    repeat (2) @(negedge clk_i);
    chk("mid_busy", 72'({mem_req_o, arb_busy_o}), 72'(2'b11));
    #2 rst_i = 1'b0;
    #1 chk("mid_rst_outs", 72'({mem_req_o, dm_ready_o, if_ready_o, arb_busy_o}), 72'(0));
    dm_req_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1; lat_fix = 0;
    @(negedge clk_i);
    chk("mid_post_idle", 72'({mem_req_o, arb_busy_o}), 72'(0));
    if_req_i = 1'b1; if_addr_i = 32'h4;
    @(negedge clk_i);
    chk("mid_new_grant", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b0, 32'h4}));
    cyc = 1;
    while (!if_ready_o && cyc < 20) begin @(negedge clk_i); cyc++; end
    chk("mid_new_ready", 72'({if_ready_o, if_rdata_o}), 72'({1'b1, sh_rd(32'h4)}));
    if_req_i = 1'b0;

    // ---- starvation bound: both requesters held continuously ----
    do_reset();
    cyc = 0;
    while (order_q.size() < 10 && cyc < 300) begin model_cycle(100); cyc++; end
    chk("starve_len", 72'(order_q.size() >= 10), 72'(1));
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_%0d", i), 72'((i < order_q.size()) ? order_q[i] : 9), 72'(exp_starve[i]));
    drain();

    // ---- randomized traffic at two load levels ----
    do_reset();
    for (int i = 0; i < 600; i++) model_cycle(35);
    drain();
    chk("rand_lo_grants", 72'(order_q.size() > 20), 72'(1));
    order_q.delete();
    for (int i = 0; i < 600; i++) model_cycle(80);
    drain();
    chk("rand_hi_grants", 72'(order_q.size() > 20), 72'(1));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
